// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for ALU_System.
// Drives every datapath control input from the current state and IROut.
// Optional feature macro: CU_PCPAST_EN adds a SAVE_PC state between
// FETCH_H and EXEC1 that copies PC into PCPast (one extra cycle per instruction).
module control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [3:0]  Flags,
    output logic        Halted
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_FETCH_L = 3'd1,
        S_FETCH_H = 3'd2,
        S_EXEC1   = 3'd3,
        S_EXEC2   = 3'd4,
`ifdef CU_PCPAST_EN
        S_SAVE_PC = 3'd6,
`endif
        S_HALT    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_flags;
    logic        w_flags_load;

    // Instruction fields: register numbers 0..3 map to RF selects 4..7
    logic [3:0]  w_op;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs;
    logic [3:0]  w_rdoh;
    logic        w_unused;

    assign w_op     = IROut[15:12];
    assign w_rd     = {1'b1, IROut[11:10]};
    assign w_rs     = {1'b1, IROut[9:8]};
    assign w_rdoh   = 4'b1000 >> IROut[11:10];
    // Immediate/address bits go straight to the datapath; RESET_PC is always clear-to-zero
    assign w_unused = ^{IROut[7:0], RESET_PC};

    // Decoded control signals (idle unless the state says otherwise)
    logic [2:0]  w_rf_outa;
    logic [2:0]  w_rf_outb;
    logic [1:0]  w_rf_fun;
    logic [3:0]  w_rf_rsel;
    logic [3:0]  w_alu_fun;
    logic [1:0]  w_arf_outc;
    logic [1:0]  w_arf_outd;
    logic [1:0]  w_arf_fun;
    logic [3:0]  w_arf_reg;
    logic        w_ir_lh;
    logic        w_ir_en;
    logic [1:0]  w_ir_fun;
    logic        w_mem_wr;
    logic        w_mem_cs;
    logic [1:0]  w_mux_a;
    logic [1:0]  w_mux_b;
    logic        w_mux_c;

    // State register: INIT on reset, otherwise follow the decoded next state
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flag latch: captures ALU flags only at the end of an ALU-op EXEC1
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_flags <= 4'b0000;
        end else if (w_flags_load) begin
            r_flags <= ALUOutFlag;
        end
    end

    // Next-state and control decode; reset low forces every output idle at once
    always_comb begin
        w_next_state = r_state;
        w_flags_load = 1'b0;
        w_rf_outa    = 3'd0;
        w_rf_outb    = 3'd0;
        w_rf_fun     = 2'b00;
        w_rf_rsel    = 4'b0000;
        w_alu_fun    = 4'h0;
        w_arf_outc   = 2'd0;
        w_arf_outd   = 2'd0;
        w_arf_fun    = 2'b00;
        w_arf_reg    = 4'b0000;
        w_ir_lh      = 1'b0;
        w_ir_en      = 1'b0;
        w_ir_fun     = 2'b00;
        w_mem_wr     = 1'b0;
        w_mem_cs     = 1'b1;
        w_mux_a      = 2'd0;
        w_mux_b      = 2'd0;
        w_mux_c      = 1'b0;

        if (!Reset_n) begin
            w_next_state = S_INIT;
        end else begin
            case (r_state)
                S_INIT: begin
                    // PC cleared to zero, IR cleared
                    w_arf_fun    = 2'b00;
                    w_arf_reg    = 4'b1000;
                    w_ir_en      = 1'b1;
                    w_ir_fun     = 2'b00;
                    w_next_state = S_FETCH_L;
                end
                S_FETCH_L, S_FETCH_H: begin
                    // Read M[PC] into one IR half, then PC++
                    w_arf_outd = 2'd3;
                    w_mem_cs   = 1'b0;
                    w_ir_en    = 1'b1;
                    w_ir_fun   = 2'b01;
                    w_arf_fun  = 2'b11;
                    w_arf_reg  = 4'b1000;
                    if (r_state == S_FETCH_H) begin
                        w_ir_lh = 1'b1;
`ifdef CU_PCPAST_EN
                        w_next_state = S_SAVE_PC;
`else
                        w_next_state = S_EXEC1;
`endif
                    end else begin
                        w_ir_lh      = 1'b0;
                        w_next_state = S_FETCH_H;
                    end
                end
`ifdef CU_PCPAST_EN
                S_SAVE_PC: begin
                    // PCPast <= PC (already pointing at the following instruction)
                    w_arf_outc   = 2'd3;
                    w_mux_b      = 2'd3;
                    w_arf_fun    = 2'b01;
                    w_arf_reg    = 4'b0001;
                    w_next_state = S_EXEC1;
                end
`endif
                S_EXEC1: begin
                    w_next_state = S_FETCH_L;
                    case (w_op)
                        4'h0: begin
                            w_mux_a   = 2'd2;
                            w_rf_fun  = 2'b01;
                            w_rf_rsel = w_rdoh;
                        end
                        4'h1, 4'h2: begin
                            // AR <= address, memory access in EXEC2
                            w_mux_b      = 2'd2;
                            w_arf_fun    = 2'b01;
                            w_arf_reg    = 4'b0100;
                            w_next_state = S_EXEC2;
                        end
                        4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                            w_rf_outa    = w_rd;
                            w_mux_c      = 1'b0;
                            w_rf_fun     = 2'b01;
                            w_rf_rsel    = w_rdoh;
                            w_mux_a      = 2'd0;
                            w_flags_load = 1'b1;
                            if (w_op <= 4'h7) begin
                                w_rf_outb = w_rs;
                            end else begin
                                w_rf_outb = 3'd0;
                            end
                            case (w_op)
                                4'h3:    w_alu_fun = 4'd4;
                                4'h4:    w_alu_fun = 4'd5;
                                4'h5:    w_alu_fun = 4'd7;
                                4'h6:    w_alu_fun = 4'd8;
                                4'h7:    w_alu_fun = 4'd10;
                                4'h8:    w_alu_fun = 4'd2;
                                4'h9:    w_alu_fun = 4'd11;
                                4'hA:    w_alu_fun = 4'd12;
                                default: w_alu_fun = 4'd0;
                            endcase
                        end
                        4'hB: begin
                            w_rf_fun  = 2'b11;
                            w_rf_rsel = w_rdoh;
                        end
                        4'hC: begin
                            w_rf_fun  = 2'b10;
                            w_rf_rsel = w_rdoh;
                        end
                        4'hD: begin
                            w_mux_b   = 2'd2;
                            w_arf_fun = 2'b01;
                            w_arf_reg = 4'b1000;
                        end
                        4'hE: begin
                            // Branch only when the latched Z flag is set
                            if (r_flags[3]) begin
                                w_mux_b   = 2'd2;
                                w_arf_fun = 2'b01;
                                w_arf_reg = 4'b1000;
                            end else begin
                                w_arf_reg = 4'b0000;
                            end
                        end
                        4'hF: begin
                            w_next_state = S_HALT;
                        end
                        default: begin
                            w_next_state = S_FETCH_L;
                        end
                    endcase
                end
                S_EXEC2: begin
                    w_arf_outd   = 2'd0;
                    w_mem_cs     = 1'b0;
                    w_next_state = S_FETCH_L;
                    if (w_op == 4'h1) begin
                        // LD: Rd <= M[AR]
                        w_mux_a   = 2'd1;
                        w_rf_fun  = 2'b01;
                        w_rf_rsel = w_rdoh;
                    end else begin
                        // ST: M[AR] <= Rd passed through the ALU
                        w_rf_outa = w_rd;
                        w_mux_c   = 1'b0;
                        w_alu_fun = 4'd0;
                        w_mem_wr  = 1'b1;
                    end
                end
                S_HALT: begin
                    w_next_state = S_HALT;
                end
                default: begin
                    w_next_state = S_INIT;
                end
            endcase
        end
    end

    assign RF_OutASel  = w_rf_outa;
    assign RF_OutBSel  = w_rf_outb;
    assign RF_FunSel   = w_rf_fun;
    assign RF_RSel     = w_rf_rsel;
    assign RF_TSel     = 4'b0000;
    assign ALU_FunSel  = w_alu_fun;
    assign ARF_OutCSel = w_arf_outc;
    assign ARF_OutDSel = w_arf_outd;
    assign ARF_FunSel  = w_arf_fun;
    assign ARF_RegSel  = w_arf_reg;
    assign IR_LH       = w_ir_lh;
    assign IR_Enable   = w_ir_en;
    assign IR_Funsel   = w_ir_fun;
    assign Mem_WR      = w_mem_wr;
    assign Mem_CS      = w_mem_cs;
    assign MuxASel     = w_mux_a;
    assign MuxBSel     = w_mux_b;
    assign MuxCSel     = w_mux_c;
    assign Flags       = r_flags;
    assign Halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: reset, fetch, decode of each
// instruction class, flag latching, conditional branch and HALT.
`timescale 1ns/1ps
module tb_control_unit;

    logic        Clock;
    logic        Reset_n;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel, RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [3:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [3:0]  Flags;
    logic        Halted;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .Flags(Flags), .Halted(Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one state; sample 2ns after the rising edge
    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    // assumes current state FETCH_L; ends in EXEC1
    task automatic do_fetch();
        chk("fetchL", {12'h000, ARF_OutDSel, 1'b0, Mem_CS, IR_Enable, IR_Funsel, IR_LH, ARF_FunSel, ARF_RegSel},
                      {12'h000, 2'd3, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b11, 4'b1000});
        step();
        chk("fetchH", {12'h000, ARF_OutDSel, 1'b0, Mem_CS, IR_Enable, IR_Funsel, IR_LH, ARF_FunSel, ARF_RegSel},
                      {12'h000, 2'd3, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b11, 4'b1000});
        step();
`ifdef CU_PCPAST_EN
        chk("savepc", {8'h00, ARF_OutCSel, MuxBSel, ARF_FunSel, ARF_RegSel},
                      {8'h00, 2'd3, 2'd3, 2'b01, 4'b0001});
        step();
`endif
    endtask

    initial begin
        Reset_n    = 1'b0;
        IROut      = 16'h0000;
        ALUOutFlag = 4'b0000;
        #12;
        chk("rst_idle", {ARF_RegSel, RF_RSel, 3'b000, IR_Enable, Mem_CS, Mem_WR, Halted, 1'b0},
                        {4'b0000, 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("rst_flags", {12'h000, Flags}, 16'h0000);
        Reset_n = 1'b1;
        #1;
        chk("init", {8'h00, ARF_FunSel, ARF_RegSel, IR_Enable, IR_Funsel, 1'b0},
                    {8'h00, 2'b00, 4'b1000, 1'b1, 2'b00, 1'b0});
        step();

        // LDI R2
        IROut = 16'h045A;
        do_fetch();
        chk("ldi", {10'h000, MuxASel, RF_FunSel, RF_RSel}, {10'h000, 2'd2, 2'b01, 4'b0100});
        step();
        chk("ldi_next_fetch", {14'h0000, IR_LH, Mem_CS}, {14'h0000, 1'b0, 1'b0});

        // LD R3,[..] : EXEC1 then EXEC2
        IROut = 16'h1900;
        do_fetch();
        chk("ld_e1", {8'h00, MuxBSel, ARF_FunSel, ARF_RegSel}, {8'h00, 2'd2, 2'b01, 4'b0100});
        step();
        chk("ld_e2", {6'h00, ARF_OutDSel, Mem_CS, Mem_WR, MuxASel, RF_FunSel, RF_RSel},
                     {6'h00, 2'd0, 1'b0, 1'b0, 2'd1, 2'b01, 4'b0010});
        step();

        // ST R4,[80] with reset asserted mid-EXEC2
        IROut = 16'h2C80;
        do_fetch();
        chk("st_e1", {8'h00, MuxBSel, ARF_FunSel, ARF_RegSel}, {8'h00, 2'd2, 2'b01, 4'b0100});
        step();
        chk("st_e2", {5'h00, RF_OutASel, ALU_FunSel, ARF_OutDSel, Mem_WR, Mem_CS},
                     {5'h00, 3'd7, 4'd0, 2'd0, 1'b1, 1'b0});
        Reset_n = 1'b0;
        #1;
        chk("st_rst_mem", {14'h0000, Mem_WR, Mem_CS}, {14'h0000, 1'b0, 1'b1});
        Reset_n = 1'b1;
        #1;
        chk("st_rst_init", {10'h000, ARF_FunSel, ARF_RegSel}, {10'h000, 2'b00, 4'b1000});
        step();

        // ADD R1,R2 with Z set, then BEQ taken
        IROut      = 16'h3100;
        ALUOutFlag = 4'b1000;
        do_fetch();
        chk("add", {RF_OutASel, RF_OutBSel, ALU_FunSel, MuxCSel, MuxASel, RF_RSel[0]},
                   {3'd4, 3'd5, 4'd4, 1'b0, 2'd0, 1'b0});
        chk("add_rsel", {10'h000, RF_FunSel, RF_RSel}, {10'h000, 2'b01, 4'b1000});
        step();
        ALUOutFlag = 4'b0000;
        chk("add_flags", {12'h000, Flags}, 16'h0008);
        IROut = 16'hE030;
        do_fetch();
        chk("beq_taken", {8'h00, MuxBSel, ARF_FunSel, ARF_RegSel}, {8'h00, 2'd2, 2'b01, 4'b1000});
        step();
        chk("beq_keeps_flags", {12'h000, Flags}, 16'h0008);

        // ADD with clear flags, then BEQ not taken
        IROut      = 16'h3100;
        ALUOutFlag = 4'b0000;
        do_fetch();
        step();
        chk("add2_flags", {12'h000, Flags}, 16'h0000);
        IROut      = 16'hE030;
        ALUOutFlag = 4'b1111;
        do_fetch();
        chk("beq_not_taken", {10'h000, MuxBSel, ARF_RegSel}, {10'h000, 2'd0, 4'b0000});
        step();
        chk("beq_nt_flags", {12'h000, Flags}, 16'h0000);

        // XOR R3,R4
        IROut      = 16'h7B00;
        ALUOutFlag = 4'b0101;
        do_fetch();
        chk("xor", {2'b00, RF_OutASel, RF_OutBSel, ALU_FunSel, RF_RSel}, {2'b00, 3'd6, 3'd7, 4'd10, 4'b0010});
        step();
        chk("xor_flags", {12'h000, Flags}, 16'h0005);

        // LSR R2 (A operand only)
        IROut = 16'hA400;
        do_fetch();
        chk("lsr", {2'b00, RF_OutASel, RF_OutBSel, ALU_FunSel, RF_RSel}, {2'b00, 3'd5, 3'd0, 4'd12, 4'b0100});
        step();

        // DEC R1 leaves flags alone
        IROut      = 16'hC000;
        ALUOutFlag = 4'b1010;
        do_fetch();
        chk("dec", {10'h000, RF_FunSel, RF_RSel}, {10'h000, 2'b10, 4'b1000});
        step();
        chk("dec_flags", {12'h000, Flags}, 16'h0005);

        // BRA
        IROut = 16'hD010;
        do_fetch();
        chk("bra", {8'h00, MuxBSel, ARF_FunSel, ARF_RegSel}, {8'h00, 2'd2, 2'b01, 4'b1000});
        step();

        // HLT
        IROut = 16'hF000;
        do_fetch();
        chk("hlt_e1", {11'h000, ARF_RegSel, Halted}, {11'h000, 4'b0000, 1'b0});
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt", {4'h0, RF_RSel, ARF_RegSel, IR_Enable, Mem_CS, Mem_WR, Halted},
                        {4'h0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1});
        end
        Reset_n = 1'b0;
        #1;
        Reset_n = 1'b1;
        #1;
        chk("halt_rst", {10'h000, Halted, ARF_RegSel, IR_Enable}, {10'h000, 1'b0, 4'b1000, 1'b1});
        step();
        chk("after_rst_fetch", {14'h0000, IR_Enable, Mem_CS}, {14'h0000, 1'b1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
